fetch_burst: RTL and testbench

- Parametrised instruction-fetch unit. Serves the core's enable/done fetch handshake through a single-line prefetch buffer.
- Refills the buffer with one AXI4 INCR read burst of LINE_WORDS 32-bit words. Sits between the core front-end and the memory-side AXI read channel.
- Hits return in one cycle. Misses cost one burst.

---
 rtl/fetch_burst.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_burst.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_burst.sv
// Instruction-fetch unit: single-line prefetch buffer refilled by one AXI4 read burst of LINE_WORDS words.
// Latency: hit or misaligned pc -> done one cycle after pcread; miss -> done the cycle after the rlast beat.
// Backpressure: arvalid is held until arready, rready is high for the whole burst; optional FETCH_CRITICAL_WORD_FIRST_EN.
module fetch_burst #(
    parameter int ADDR_W     = 29,
    parameter int LINE_WORDS = 8,
    parameter int AXI_ID     = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic [31:0]       pc,
    input  logic              flush,
    output logic              pcread,
    output logic              done,
    output logic [31:0]       command,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic [1:0]        arburst,
    output logic [3:0]        arcache,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic              arlock,
    output logic [2:0]        arprot,
    output logic [3:0]        arqos,
    input  logic              arready,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic [31:0]       rdata,
    input  logic [3:0]        rid,
    input  logic              rlast,
    output logic              rready,
    input  logic [1:0]        rresp,
    input  logic              rvalid
);
    localparam int LB    = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - LB;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              line_vld;
    logic [TAG_W-1:0]  line_tag;
    logic [31:0]       line_buf [LINE_WORDS];
    logic [LB-1:0]     idx_q;
    logic [LB-1:0]     cnt;
    logic [LB-1:0]     wr_idx;
    logic              err_stk;
    logic              flush_pend;

    logic              accept;
    logic              misaligned;
    logic              hit;
    logic              ar_hs;
    logic              r_hs;
    logic              beat_err;
    logic              line_ok;
    logic [TAG_W-1:0]  pc_tag;
    logic [LB-1:0]     pc_idx;
    logic [ADDR_W-1:0] ar_start;
    logic              unused_rid;

    // rid carries no information with a single outstanding burst
    assign unused_rid = ^rid;

    assign pc_tag     = pc[31:LB+2];
    assign pc_idx     = pc[LB+1:2];
    assign accept     = (state == IDLE) && enable;
    assign pcread     = accept && rstn;
    assign misaligned = (pc[1:0] != 2'b00);
    assign hit        = line_vld && !flush && (line_tag == pc_tag);
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign beat_err   = (rresp != 2'b00);
    // a refill only becomes usable if no beat errored and nobody flushed meanwhile
    assign line_ok    = !err_stk && !beat_err && !flush_pend && !flush;

`ifdef FETCH_CRITICAL_WORD_FIRST_EN
    assign ar_start = ADDR_W'({pc[31:2], 2'b00});
    assign arburst  = 2'b10;
    assign wr_idx   = idx_q + cnt;
`else
    assign ar_start = ADDR_W'({pc_tag, {(LB+2){1'b0}}});
    assign arburst  = 2'b01;
    assign wr_idx   = cnt;
`endif

    assign arcache = 4'b0011;
    assign arid    = 4'(AXI_ID);
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arlock  = 1'b0;
    assign arprot  = 3'b000;
    assign arqos   = 4'b0000;
    assign arsize  = 3'b010;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state: a miss walks ADDR -> DATA (-> DRAIN) -> IDLE, rlast ends the burst
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !misaligned && !hit) state_nxt = ADDR;
            end
            ADDR: begin
                if (ar_hs) state_nxt = DATA;
            end
            DATA: begin
`ifdef FETCH_CRITICAL_WORD_FIRST_EN
                if (r_hs) state_nxt = rlast ? IDLE : DRAIN;
`else
                if (r_hs && rlast) state_nxt = IDLE;
`endif
            end
            DRAIN: begin
`ifdef FETCH_CRITICAL_WORD_FIRST_EN
                if (r_hs && rlast) state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // line storage, written once per accepted read beat
    always_ff @(posedge clk) begin
        if (r_hs && (state == DATA || state == DRAIN)) line_buf[wr_idx] <= rdata;
    end

    // request handling, AXI control and core-side response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done       <= 1'b0;
            err        <= 1'b0;
            command    <= 32'h0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            line_vld   <= 1'b0;
            line_tag   <= '0;
            idx_q      <= '0;
            cnt        <= '0;
            err_stk    <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) line_vld <= 1'b0;
                    if (accept) begin
                        idx_q <= pc_idx;
                        if (misaligned) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (hit) begin
                            done    <= 1'b1;
                            err     <= 1'b0;
                            command <= line_buf[pc_idx];
                        end else begin
                            // the line is overwritten from here on, so it is invalid until refilled
                            araddr     <= ar_start;
                            arvalid    <= 1'b1;
                            line_vld   <= 1'b0;
                            line_tag   <= pc_tag;
                            cnt        <= '0;
                            err_stk    <= 1'b0;
                            flush_pend <= 1'b0;
                        end
                    end
                end
                ADDR: begin
                    if (flush) flush_pend <= 1'b1;
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                DATA, DRAIN: begin
                    if (flush) flush_pend <= 1'b1;
                    if (r_hs) begin
                        cnt <= cnt + 1'b1;
                        if (beat_err) err_stk <= 1'b1;
`ifdef FETCH_CRITICAL_WORD_FIRST_EN
                        // the first beat is the requested word: answer the core right away
                        if (state == DATA) begin
                            done    <= 1'b1;
                            err     <= beat_err;
                            command <= rdata;
                        end
                        if (rlast) begin
                            rready   <= 1'b0;
                            cnt      <= '0;
                            line_vld <= line_ok;
                        end
`else
                        if (rlast) begin
                            rready   <= 1'b0;
                            cnt      <= '0;
                            line_vld <= line_ok;
                            done     <= 1'b1;
                            err      <= err_stk | beat_err;
                            // the requested word may be arriving on this very beat
                            command  <= (cnt == idx_q) ? rdata : line_buf[idx_q];
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_burst.sv
module tb_fetch_burst;
    localparam int ADDR_W = 29;
    localparam int LW     = 8;

    logic              clk;
    logic              rstn;
    logic              enable;
    logic [31:0]       pc;
    logic              flush;
    logic              pcread;
    logic              done;
    logic [31:0]       command;
    logic              err;
    logic [ADDR_W-1:0] araddr;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic              arlock;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arready;
    logic [2:0]        arsize;
    logic              arvalid;
    logic [31:0]       rdata;
    logic [3:0]        rid;
    logic              rlast;
    logic              rready;
    logic [1:0]        rresp;
    logic              rvalid;

    fetch_burst #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .AXI_ID(0)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .pc(pc), .flush(flush),
        .pcread(pcread), .done(done), .command(command), .err(err),
        .araddr(araddr), .arburst(arburst), .arcache(arcache), .arid(arid),
        .arlen(arlen), .arlock(arlock), .arprot(arprot), .arqos(arqos),
        .arready(arready), .arsize(arsize), .arvalid(arvalid),
        .rdata(rdata), .rid(rid), .rlast(rlast), .rready(rready),
        .rresp(rresp), .rvalid(rvalid)
    );

    typedef struct {
        logic [31:0] cmd;
        logic        err;
        bit          chk_cmd;
    } exp_t;

    exp_t sb[$];
    int   total      = 0;
    int   bad        = 0;
    int   ar_count   = 0;
    int   beats_acc  = 0;
    int   err_beat   = -1;
    int   flush_beat = -1;

`ifdef FETCH_CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
    localparam bit         CWF       = 1'b1;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
    localparam bit         CWF       = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory image: the word at byte address a holds 0x1000 + a/4
    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] c, input logic e, input bit cc);
        exp_t x;
        x.cmd = c; x.err = e; x.chk_cmd = cc;
        sb.push_back(x);
    endtask

    // one-cycle request: enable is raised until pcread is seen, then dropped after the accepting edge
    task automatic req(input logic [31:0] p);
        int n = 0;
        @(negedge clk);
        enable = 1'b1;
        pc     = p;
        #1;
        while (!pcread && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("pcread", pcread, 1);
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    // called at posedge+1 right after req; lat >= 0 demands done with that many extra cycles
    task automatic wait_done(input string tag, input int lat);
        int   n = 0;
        exp_t x;
        while (!done && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_done"}, done, 1);
        if (done) begin
            if (lat >= 0) chk({tag, "_lat"}, n, lat);
            chk({tag, "_sb"}, (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.chk_cmd) chk({tag, "_cmd"}, command, x.cmd);
                chk({tag, "_err"}, err, x.err);
            end
            @(posedge clk); #1;
            chk({tag, "_pulse"}, done, 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rready || arvalid) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("idle", rready | arvalid, 0);
    endtask

    // AXI read slave: arready two cycles after arvalid, then one beat per cycle
    task automatic serve();
        logic [31:0] a, base, addr;
        logic [1:0]  bt;
        int          len;
        bit          abort = 0;
        bit          hs;
        bit          moved;
        int          guard;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (!rstn) abort = 1;
        end
        if (!abort) begin
            arready = 1'b1;
            a   = 32'(araddr);
            bt  = arburst;
            len = int'(arlen);
            @(negedge clk);
            arready = 1'b0;
            if (!rstn) abort = 1;
            else ar_count++;
        end
        for (int k = 0; k <= len && !abort; k++) begin
            base = a & ~(32'((len + 1) * 4) - 1);
            if (bt == 2'b10) addr = base + 32'((((a - base) / 4 + k) % (len + 1)) * 4);
            else             addr = a + 32'(4 * k);
            rvalid = 1'b1;
            rdata  = memw(addr);
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            rlast  = (k == len);
            flush  = (k == flush_beat);
            moved  = 0;
            guard  = 0;
            while (!moved && !abort) begin
                hs = rready;
                @(negedge clk);
                flush = 1'b0;
                if (!rstn) abort = 1;
                else if (hs) begin beats_acc++; moved = 1; end
                else if (++guard > 50) abort = 1;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        flush  = 1'b0;
    endtask

    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b0; rid = 4'h0; flush = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && arvalid) serve();
        end
    end

    initial begin
        int b0;
        int n;
        rstn = 1'b0; enable = 1'b0; pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_pcread", pcread, 0);
        chk("rst_err", err, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_command", command, 0);
        chk("rst_araddr", araddr, 0);
        chk("c_arlen", arlen, 7);
        chk("c_arburst", arburst, EXP_BURST);
        chk("c_arsize", arsize, 3'b010);
        chk("c_arcache", arcache, 4'b0011);
        chk("c_misc", {arid, arlock, arprot, arqos}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // cold miss at 0x100
        push(32'h1040, 1'b0, 1'b1);
        req(32'h100);
        chk("fill_arvalid", arvalid, 1);
        chk("fill_araddr", araddr, 32'h100);
        chk("fill_arlen", arlen, 7);
        wait_done("fill", -1);
        wait_idle();
        chk("fill_beats", beats_acc, 8);
        chk("fill_ars", ar_count, 1);

        // back-to-back hits
        push(32'h1041, 1'b0, 1'b1);
        req(32'h104);
        chk("hit1_arvalid", arvalid, 0);
        wait_done("hit1", 0);
        push(32'h1047, 1'b0, 1'b1);
        req(32'h11C);
        chk("hit2_arvalid", arvalid, 0);
        wait_done("hit2", 0);
        chk("hits_ars", ar_count, 1);

        // error response on beat 3, then the same line must be fetched again
        err_beat = 3;
        push(32'h0, CWF ? 1'b0 : 1'b1, 1'b0);
        req(32'h120);
        wait_done("rerr", -1);
        wait_idle();
        err_beat = -1;
        chk("rerr_ars", ar_count, 2);
        push(32'h1048, 1'b0, 1'b1);
        req(32'h120);
        chk("refetch_arvalid", arvalid, 1);
        wait_done("refetch", -1);
        wait_idle();
        chk("refetch_ars", ar_count, 3);

        // flush during the data phase: burst completes, line stays invalid
        flush_beat = 2;
        b0 = beats_acc;
        push(32'h1040, 1'b0, 1'b1);
        req(32'h100);
        wait_done("flushfill", -1);
        wait_idle();
        flush_beat = -1;
        chk("flush_beats", beats_acc - b0, 8);
        push(32'h1041, 1'b0, 1'b1);
        req(32'h104);
        chk("postflush_arvalid", arvalid, 1);
        wait_done("postflush", -1);
        wait_idle();

        // misaligned pc: error next cycle, command untouched, no AXI access
        push(32'h1041, 1'b1, 1'b1);
        req(32'h102);
        chk("mis_arvalid", arvalid, 0);
        wait_done("mis", 0);
        chk("mis_ars", ar_count, 5);

        // reset in the middle of a burst
        req(32'h200);
        n = 0;
        while (!rready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("mid_rready_up", rready, 1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_arvalid", arvalid, 0);
        chk("mid_rready", rready, 0);
        chk("mid_done", done, 0);
        chk("mid_command", command, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push(32'h1041, 1'b0, 1'b1);
        req(32'h104);
        chk("postrst_arvalid", arvalid, 1);
        wait_done("postrst", -1);
        wait_idle();

        // miss in the middle of a line, then a hit on its first word
        push(32'h104D, 1'b0, 1'b1);
        req(32'h134);
        chk("mid_araddr", araddr, CWF ? 32'h134 : 32'h120);
        wait_done("midline", -1);
        wait_idle();
        push(32'h1048, 1'b0, 1'b1);
        req(32'h120);
        chk("midhit_arvalid", arvalid, 0);
        wait_done("midhit", 0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
